ej32_stor: RTL and testbench
============================

EJ32_STOR -- requirements
Module: ej32_stor

Interface
REQ-001 Parameter DSZ, 32, data word width in bits.
REQ-002 Parameter ASZ, 16, byte address width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port req_vld  input  1  store request valid.
REQ-006 Port req_rdy  output  1  block can accept a request.
REQ-007 Port req_addr  input  ASZ  byte address of the first (most significant) byte.
REQ-008 Port req_data  input  DSZ  value to store, right-justified.
REQ-009 Port req_size  input  2  encoding: 0 = byte, 1 = short, 2 = word, 3 = reserved.
REQ-010 Port mem_we  output  1  byte write strobe to the memory bus.
REQ-011 Port mem_addr  output  ASZ  byte write address.
REQ-012 Port mem_data  output  8  byte write data.
REQ-013 Port mem_rdy  input  1  memory accepts the current byte.
REQ-014 Port busy  output  1  transfer in progress.
REQ-015 Port done  output  1  one-cycle pulse after the final byte is accepted.
REQ-016 Port err  output  1  one-cycle pulse after a reserved-size request.

Function
REQ-017 The block serializes one store request (bastore, sastore or iastore) into 1, 2 or 4 byte writes, in big-endian order.
REQ-018 The FSM has exactly three states: IDLE, XFER and FIN.
- req_rdy = 1 only in IDLE.
- A request is accepted when req_vld & req_rdy are both high.
REQ-019 On acceptance with size 0/1/2:
- capture req_addr and the byte count N = 1/2/4;
- capture req_data pre-shifted left by (4-N)*8 bits;
- go to XFER.
REQ-020 In XFER:
- mem_we = 1;
- mem_data = shift register bits [31:24];
- mem_addr = current address.
REQ-021 A byte is accepted when mem_we & mem_rdy are both high. On acceptance:
- shift left by 8;
- increment the address;
- decrement the remaining count.
REQ-022 When mem_rdy is low, mem_we, mem_addr and mem_data hold unchanged.
REQ-023 After the last byte is accepted, the next state is FIN. FIN lasts one cycle with done = 1 and mem_we = 0, then goes to IDLE.
REQ-024 Byte order for a word: req_data[31:24] at addr, then [23:16] at addr+1, [15:8] at addr+2, [7:0] at addr+3. For a short: [15:8] at addr, then [7:0] at addr+1. For a byte: [7:0] at addr.
REQ-025 The address increment wraps from 2^ASZ-1 to 0 with no error.
REQ-026 Latency with mem_rdy held high, counting the accept cycle as cycle 0:
- bytes are written in cycles 1..N;
- done is high in cycle N+1;
- the next request can be accepted in cycle N+2.
REQ-027 A size-3 request is accepted but performs no write. err = 1 for exactly one cycle in the following cycle, and the state stays IDLE.
REQ-028 busy = 1 in XFER and FIN; otherwise busy = 0.
REQ-029 While busy is high, req_vld and all req_* inputs are ignored; a request held through busy is accepted on the first IDLE cycle.
REQ-030 mem_we, mem_addr, mem_data, done and err are all driven from registers; no combinational path exists from any input to any output.

Reset
REQ-031 On rst = 1 at a clock edge, the block enters IDLE with the reset output values below, whatever state it was in.
- Outputs after reset: mem_we = 0, mem_addr = 0, mem_data = 0, busy = 0, done = 0, err = 0, req_rdy = 1.
- The remaining count and the shift register are cleared.
REQ-032 Reset during XFER aborts the transfer: no further bytes are written and no done pulse is generated.
REQ-033 rst takes priority over a simultaneous request or byte acceptance.

Structure
REQ-034 The types stor_size_t (BYTE, SHORT, WORD, RSVD) and stor_state_t (IDLE, XFER, FIN) belong in ej32_pkg.
REQ-035 The block is a single module with no sub-modules; the counter and shift register are local.

Verification
REQ-036 Word store, mem_rdy = 1: req_addr = 0x0100, req_data = 0x11223344, size 2.
- Required writes: 0x11@0x0100, 0x22@0x0101, 0x33@0x0102, 0x44@0x0103 in consecutive cycles.
- done pulses in cycle 5.
REQ-037 Short store with stalls: req_addr = 0x0200, req_data = 0xDEADBEEF, size 1, mem_rdy low for 2 cycles before each byte.
- Required writes: 0xBE@0x0200, then 0xEF@0x0201.
- Outputs hold stable during stalls; done follows the second acceptance.
REQ-038 Byte store at wrap: req_addr = 0xFFFF, req_data = 0x000000A5, size 0 -> single write 0xA5@0xFFFF, done in cycle 2. Then a short at 0xFFFF with data 0x1234 -> 0x12@0xFFFF, then 0x34@0x0000.
REQ-039 Reserved size: size 3 -> no mem_we, err = 1 for one cycle, req_rdy = 1 on the following cycle.
REQ-040 Reset mid-transfer: assert rst after the second byte of a word store -> mem_we = 0 from the next cycle, no done, and req_rdy = 1 after reset.
REQ-041 Back-to-back requests: req_vld held high with a second request queued behind a word store -> the second request is accepted in cycle 6, and no byte is lost or duplicated.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared types for the ej32 store serializer: request size encoding,
// FSM state encoding and the size-to-byte-count mapping.
package ej32_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        SHORT = 2'd1,
        WORD  = 2'd2,
        RSVD  = 2'd3
    } stor_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        FIN  = 2'd2
    } stor_state_t;

    function automatic logic [2:0] byteCount(input stor_size_t size);
        logic [2:0] count;
        case (size)
            BYTE:    count = 3'd1;
            SHORT:   count = 3'd2;
            default: count = 3'd4;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/ej32_stor.sv
// Store serializer: turns one bastore/sastore/iastore request into 1, 2 or 4
// big-endian byte writes on a ready-throttled byte bus.
module ej32_stor
    import ej32_pkg::*;
#(
    parameter int DSZ = 32,
    parameter int ASZ = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_vld,
    output logic           req_rdy,
    input  logic [ASZ-1:0] req_addr,
    input  logic [DSZ-1:0] req_data,
    input  logic [1:0]     req_size,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_addr,
    output logic [7:0]     mem_data,
    input  logic           mem_rdy,
    output logic           busy,
    output logic           done,
    output logic           err
);

    stor_state_t    state_q, state_d;
    logic [ASZ-1:0] addr_q, addr_d;
    logic [DSZ-1:0] shift_q, shift_d;
    logic [2:0]     count_q, count_d;
    logic           err_q, err_d;

    stor_size_t     reqSize;
    logic [2:0]     reqCount;

    assign reqSize  = stor_size_t'(req_size);
    assign reqCount = byteCount(reqSize);

    // Data is left-aligned on capture so the outgoing byte is always the top
    // byte of the shift register, whatever the request size.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        count_d = count_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if (reqSize == RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        count_d = reqCount;
                        shift_d = req_data << {3'd4 - reqCount, 3'b000};
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                if (mem_rdy) begin
                    shift_d = shift_q << 8;
                    addr_d  = addr_q + ASZ'(1);
                    count_d = count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            shift_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Every output is a decode of registered state only.
    assign req_rdy  = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign mem_we   = (state_q == XFER);
    assign done     = (state_q == FIN);
    assign err      = err_q;
    assign mem_addr = addr_q;
    assign mem_data = shift_q[DSZ-1 -: 8];

endmodule

// File: tb/tb_ej32_stor.sv
// Self-checking bench for ej32_stor: directed scenarios plus randomized
// stores checked against a byte-list reference of big-endian stores.
module tb_ej32_stor;

    logic        clk;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [15:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_rdy;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    ej32_stor #(.DSZ(32), .ASZ(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_size(req_size),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_rdy (mem_rdy),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic randomBusyInputs();
        req_vld  = 1'($urandom_range(0, 1));
        req_addr = 16'($urandom);
        req_data = $urandom;
        req_size = 2'($urandom_range(0, 3));
    endtask

    // Issue one request from IDLE and follow it cycle by cycle. stall < 0 picks
    // a random 0..2 stall before each byte. With chain set, the next request is
    // presented (req_vld high) throughout the transfer and left in place.
    task automatic applyStimulus(input logic [15:0] a, input logic [31:0] d,
                                 input logic [1:0] s, input int stall,
                                 input bit chain, input logic [15:0] na,
                                 input logic [31:0] nd, input logic [1:0] ns);
        int n;
        int k;
        logic [7:0]  expByte;
        logic [15:0] expAddr;
        req_vld  = 1'b1;
        req_addr = a;
        req_data = d;
        req_size = s;
        mem_rdy  = 1'($urandom_range(0, 1));
        checkOutput("accept_rdy", req_rdy, 1);
        checkOutput("accept_busy", busy, 0);
        checkOutput("accept_we", mem_we, 0);
        step();
        if (chain) begin
            req_vld  = 1'b1;
            req_addr = na;
            req_data = nd;
            req_size = ns;
        end else begin
            req_vld = 1'b0;
        end
        if (s == 2'd3) begin
            checkOutput("rsvd_err", err, 1);
            checkOutput("rsvd_we", mem_we, 0);
            checkOutput("rsvd_rdy", req_rdy, 1);
            checkOutput("rsvd_busy", busy, 0);
            step();
            checkOutput("rsvd_err_clear", err, 0);
            checkOutput("rsvd_we_after", mem_we, 0);
            return;
        end
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            expByte = 8'(d >> ((n - 1 - i) * 8));
            expAddr = a + 16'(i);
            k = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int j = 0; j < k; j++) begin
                mem_rdy = 1'b0;
                if (!chain) randomBusyInputs();
                checkOutput("stall_we", mem_we, 1);
                checkOutput("stall_addr", mem_addr, expAddr);
                checkOutput("stall_data", mem_data, expByte);
                checkOutput("stall_done", done, 0);
                step();
            end
            mem_rdy = 1'b1;
            if (!chain) randomBusyInputs();
            checkOutput("byte_we", mem_we, 1);
            checkOutput("byte_addr", mem_addr, expAddr);
            checkOutput("byte_data", mem_data, expByte);
            checkOutput("byte_busy", busy, 1);
            checkOutput("byte_rdy", req_rdy, 0);
            step();
        end
        mem_rdy = 1'($urandom_range(0, 1));
        checkOutput("fin_done", done, 1);
        checkOutput("fin_we", mem_we, 0);
        checkOutput("fin_busy", busy, 1);
        checkOutput("fin_rdy", req_rdy, 0);
        checkOutput("fin_err", err, 0);
        step();
        checkOutput("post_done", done, 0);
        checkOutput("post_busy", busy, 0);
        checkOutput("post_rdy", req_rdy, 1);
        if (!chain) req_vld = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req_vld  = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_size = '0;
        mem_rdy  = 1'b0;
        #1;
        step();
        step();
        checkOutput("reset_we", mem_we, 0);
        checkOutput("reset_addr", mem_addr, 0);
        checkOutput("reset_data", mem_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_rdy", req_rdy, 1);
        rst = 1'b0;

        $display("[TB] word store");
        applyStimulus(16'h0100, 32'h11223344, 2'd2, 0, 1'b0, '0, '0, '0);
        $display("[TB] short store with stalls");
        applyStimulus(16'h0200, 32'hDEADBEEF, 2'd1, 2, 1'b0, '0, '0, '0);
        $display("[TB] byte and short at address wrap");
        applyStimulus(16'hFFFF, 32'h000000A5, 2'd0, 0, 1'b0, '0, '0, '0);
        applyStimulus(16'hFFFF, 32'h00001234, 2'd1, 0, 1'b0, '0, '0, '0);
        $display("[TB] reserved size");
        applyStimulus(16'h0040, 32'h12345678, 2'd3, 0, 1'b0, '0, '0, '0);
        $display("[TB] back-to-back requests");
        applyStimulus(16'h0300, 32'hCAFEF00D, 2'd2, 0, 1'b1, 16'h0400, 32'h55667788, 2'd2);
        applyStimulus(16'h0400, 32'h55667788, 2'd2, 0, 1'b0, '0, '0, '0);

        $display("[TB] reset mid-transfer");
        req_vld  = 1'b1;
        req_addr = 16'h0500;
        req_data = 32'h0A0B0C0D;
        req_size = 2'd2;
        step();
        req_vld = 1'b0;
        mem_rdy = 1'b1;
        checkOutput("mid_byte0", mem_data, 32'h0A);
        step();
        checkOutput("mid_byte1", mem_data, 32'h0B);
        checkOutput("mid_addr1", mem_addr, 32'h0501);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort_we", mem_we, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rdy", req_rdy, 1);
        checkOutput("abort_addr", mem_addr, 0);
        checkOutput("abort_data", mem_data, 0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("abort_no_done", done, 0);
            checkOutput("abort_no_we", mem_we, 0);
            step();
        end

        $display("[TB] randomized stores");
        for (int t = 0; t < 40; t++) begin
            applyStimulus(16'($urandom), $urandom, 2'($urandom_range(0, 3)), -1,
                          1'b0, '0, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
